// File: rtl/timer_counter.sv
// Memory-mapped countdown timer on the CPU data bus.
// Software programs CTRL and PRESET with ordinary stores. The timer counts
// COUNT down from PRESET and raises irq toward one CP0 HWInt bit.
// Mode 0 (and 2/3) is one-shot. Mode 1 reloads and pulses irq for one cycle.
module timer_counter #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_CNT  = 2'd2;
   localparam logic [1:0] ST_INT  = 2'd3;

   localparam logic [1:0] OFS_CTRL   = 2'd0;
   localparam logic [1:0] OFS_PRESET = 2'd1;
   localparam logic [1:0] OFS_COUNT  = 2'd2;

   logic        en;
   logic [1:0]  mode;
   logic        im;
   logic [31:0] preset;
   logic [31:0] count;
   logic [1:0]  state;
   logic        irq_flag;

   logic        hit;
   logic [1:0]  sel;
   logic        ctrl_wr;
   logic        preset_wr;
   logic        unused_addr_bits;

   assign hit              = (addr[31:4] == BASE_ADDR[31:4]);
   assign sel              = addr[3:2];
   assign ctrl_wr          = we && hit && (sel == OFS_CTRL);
   assign preset_wr        = we && hit && (sel == OFS_PRESET);
   assign unused_addr_bits = ^addr[1:0];

   assign irq = im & irq_flag;

   // CTRL register; a software write takes priority over the one-shot En clear
   always_ff @(posedge clk) begin
      if (reset) begin
         en   <= 1'b0;
         mode <= 2'd0;
         im   <= 1'b0;
      end else if (ctrl_wr) begin
         en   <= din[0];
         mode <= din[2:1];
         im   <= din[3];
      end else if (state == ST_INT && mode != 2'd1) begin
         en   <= 1'b0;
      end
   end

   // PRESET register; only consumed when the FSM passes through LOAD
   always_ff @(posedge clk) begin
      if (reset) begin
         preset <= 32'd0;
      end else if (preset_wr) begin
         preset <= din;
      end
   end

   // Countdown FSM with COUNT and the interrupt flag; any CTRL write clears the flag
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         count    <= 32'd0;
         irq_flag <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (en) begin
                  state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               count <= preset;
               state <= ST_CNT;
            end
            ST_CNT: begin
               if (!en) begin
                  state <= ST_IDLE;
               end else if (count > 32'd1) begin
                  count <= count - 32'd1;
               end else begin
                  count    <= 32'd0;
                  irq_flag <= 1'b1;
                  state    <= ST_INT;
               end
            end
            default: begin
               if (mode == 2'd1) begin
                  irq_flag <= 1'b0;
               end
               state <= ST_IDLE;
            end
         endcase
         if (ctrl_wr) begin
            irq_flag <= 1'b0;
         end
      end
   end

   // Combinational read mux; misses and the spare offset read as zero
   always_comb begin
      dout = 32'd0;
      if (hit) begin
         case (sel)
            OFS_CTRL:   dout = {28'd0, im, mode, en};
            OFS_PRESET: dout = preset;
            OFS_COUNT:  dout = count;
            default:    dout = 32'd0;
         endcase
      end
   end

endmodule
